buff_reader: RTL and testbench
==============================

BUFF_READER -- requirements
Module: buff_reader

Interface
REQ-001 SHALL have parameter NBADD, default 12, meaning buffer address width in bits.
REQ-002 SHALL have parameter NBITS, default 16, meaning half-word width (data word is 2*NBITS bits).
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  begin a readout; sampled only in IDLE.
REQ-006 SHALL have port len  input  NBADD  number of words to read; 0 means 2**NBADD words.
REQ-007 SHALL have port rd_addr  output  NBADD  address driven to the sample buffer.
REQ-008 SHALL have port rd_data  input  2*NBITS  signed buffer word at rd_addr, combinational from the buffer.
REQ-009 SHALL have port dout  output  2*NBITS  signed stream data, registered.
REQ-010 SHALL have port dout_valid  output  1  dout holds a valid word.
REQ-011 SHALL have port dout_ready  input  1  downstream accepts the word.
REQ-012 SHALL have port dout_last  output  1  marks the final word of the readout.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse on readout completion.

Function
REQ-015 SHALL implement states IDLE, FETCH, SEND, DONE (plus CKSUM when enabled, REQ-030).
REQ-016 IDLE: start=1 SHALL latch len, clear word counter, set rd_addr=0, go to FETCH next cycle.
REQ-017 FETCH: SHALL register rd_data into dout, assert dout_valid, go to SEND; lasts exactly one cycle.
REQ-018 SEND: dout, dout_valid, dout_last SHALL stay stable while dout_valid=1 and dout_ready=0.
REQ-019 A transfer SHALL occur on any cycle with dout_valid=1 and dout_ready=1; dout_valid drops the next cycle unless a new word is loaded.
REQ-020 On transfer of a non-final word SHALL increment rd_addr and counter and go to FETCH.
REQ-021 On transfer of the final data word SHALL go to DONE (or CKSUM when enabled).
REQ-022 DONE: SHALL assert done for exactly one cycle, then return to IDLE.
REQ-023 Latency: first dout_valid SHALL rise 2 cycles after start sampled; back-to-back words with dout_ready held high SHALL appear every 2 cycles.
REQ-024 start while busy=1 SHALL be ignored; len changes after latching SHALL have no effect.
REQ-025 rd_addr SHALL wrap modulo 2**NBADD; len=0 SHALL read addresses 0..2**NBADD-1 inclusive.
REQ-026 dout_last SHALL be 1 only with dout_valid=1 on the final word of the readout.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, rd_addr=0, dout=0, dout_valid=0, dout_last=0, busy=0, done=0, counter=0, checksum=0.
REQ-028 rst asserted mid-readout SHALL abort it with no done pulse; a new start after rst release SHALL restart at address 0.

Configuration
REQ-029 Macro BUFF_READER_CKSUM_EN SHALL select checksum trailer support.
REQ-030 With BUFF_READER_CKSUM_EN defined: SHALL accumulate the modulo 2**(2*NBITS) sum of all transferred data words, then in CKSUM present that sum on dout as one extra word with dout_last=1 (data words have dout_last=0), under REQ-018 handshake rules, then go to DONE.
REQ-031 Without BUFF_READER_CKSUM_EN: no CKSUM state or accumulator; dout_last SHALL mark the final data word.

Verification
REQ-032 Buffer words 0x00010002, 0x00030004, 0x00050006 at 0..2, len=3, dout_ready=1 -> three words in order, dout_last on third, done 1 cycle after final transfer.
REQ-033 Same stimulus, dout_ready low 5 cycles while word 2 valid -> dout stays 0x00030004, dout_valid stays high, no address advance.
REQ-034 NBADD=4, len=0, buffer holds addr value -> 16 words 0..15, rd_addr wraps to 0, single done pulse.
REQ-035 rst pulse during word 2 of len=8 -> all outputs 0 within the reset, no done; next start yields address 0 first.
REQ-036 start pulsed again mid-readout -> ignored, word count unchanged.
REQ-037 With BUFF_READER_CKSUM_EN, words 0xFFFFFFFF, 0x00000002, len=2 -> third word 0x00000001 with dout_last=1.

Source files
------------

// File: rtl/buff_reader.sv
// Streams len words from a combinational-read sample buffer out of a ready/valid port.
// Define BUFF_READER_CKSUM_EN to append a modulo-2**(2*NBITS) sum of the data words as a trailer word.
module buff_reader #(
  parameter int NBADD = 12,
  parameter int NBITS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NBADD-1:0]          len,
  output logic [NBADD-1:0]          rd_addr,
  input  logic signed [2*NBITS-1:0] rd_data,
  output logic signed [2*NBITS-1:0] dout,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic                      dout_last,
  output logic                      busy,
  output logic                      done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
`ifdef BUFF_READER_CKSUM_EN
  localparam logic [2:0] S_CKSUM = 3'd4;
  logic [2*NBITS-1:0] sum;
`endif

  logic [2:0]       state;
  logic [NBADD-1:0] len_q;
  logic [NBADD-1:0] cnt;
  logic             final_word;

  // len_q of zero makes len_q-1 all ones, so a zero length naturally reads the whole buffer
  assign final_word = (cnt == len_q - NBADD'(1));
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      len_q      <= '0;
      cnt        <= '0;
      rd_addr    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
`ifdef BUFF_READER_CKSUM_EN
      sum        <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q   <= len;
            cnt     <= '0;
            rd_addr <= '0;
`ifdef BUFF_READER_CKSUM_EN
            sum     <= '0;
`endif
            state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          dout       <= rd_data;
          dout_valid <= 1'b1;
`ifdef BUFF_READER_CKSUM_EN
          dout_last  <= 1'b0;
`else
          dout_last  <= final_word;
`endif
          state      <= S_SEND;
        end
        S_SEND: begin
          // dout_valid is always set here, so ready alone marks a transfer
          if (dout_ready) begin
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            rd_addr    <= rd_addr + 1'b1;
`ifdef BUFF_READER_CKSUM_EN
            sum        <= sum + dout;
`endif
            if (final_word) begin
`ifdef BUFF_READER_CKSUM_EN
              state <= S_CKSUM;
`else
              state <= S_DONE;
`endif
            end else begin
              cnt   <= cnt + 1'b1;
              state <= S_FETCH;
            end
          end
        end
`ifdef BUFF_READER_CKSUM_EN
        S_CKSUM: begin
          if (!dout_valid) begin
            dout       <= sum;
            dout_valid <= 1'b1;
            dout_last  <= 1'b1;
          end else if (dout_ready) begin
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            state      <= S_DONE;
          end
        end
`endif
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buff_reader.sv
// Randomized bench for buff_reader with a queue-based reference of the expected word stream.
module tb_buff_reader;
  localparam int NBADD = 4;
  localparam int NBITS = 16;
  localparam int W     = 2 * NBITS;
  localparam int DEPTH = 1 << NBADD;

  logic                  clk = 1'b0;
  logic                  rst, start, dout_ready;
  logic [NBADD-1:0]      len, rd_addr;
  logic signed [W-1:0]   rd_data, dout;
  logic                  dout_valid, dout_last, busy, done;
  logic [W-1:0]          mem [DEPTH];
  logic [W-1:0]          last_word;
  int                    words_seen;
  int total = 0;
  int bad   = 0;

  buff_reader #(.NBADD(NBADD), .NBITS(NBITS)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .rd_addr(rd_addr),
    .rd_data(rd_data), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last), .busy(busy), .done(done)
  );

  assign rd_data = mem[rd_addr];
  always #5 clk = ~clk;

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
  endtask

  // One readout of n words (0 = whole buffer); expected stream is built from mem up front.
  task automatic readout(input int n, input int ready_pct, input int stall_idx,
                         input int stall_len, input int restart_cyc, input bit cadence);
    logic [W-1:0] exp_q[$];
    logic [W-1:0] acc, prev_dout;
    logic [NBADD-1:0] prev_addr;
    int nwords, ndata, idx, cyc, last_xfer, stall_left;
    bit prev_hold, prev_last, finished;
    ndata = (n == 0) ? DEPTH : n;
    acc = '0;
    for (int i = 0; i < ndata; i++) begin
      exp_q.push_back(mem[i % DEPTH]);
      acc = acc + mem[i % DEPTH];
    end
`ifdef BUFF_READER_CKSUM_EN
    exp_q.push_back(acc);
`endif
    nwords = exp_q.size();
    idx = 0; cyc = 0; last_xfer = -10; stall_left = stall_len;
    prev_hold = 0; prev_last = 0; prev_dout = '0; prev_addr = '0; finished = 0;
    words_seen = 0;
    @(negedge clk);
    len = NBADD'(n); start = 1'b1; dout_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; len = NBADD'($urandom);
    while (cyc < 600) begin
      if (prev_hold) begin
        total++;
        if (dout !== prev_dout || dout_valid !== 1'b1 || dout_last !== prev_last || rd_addr !== prev_addr) begin
          bad++;
          $display("FAIL hold cyc=%0d dout=%h valid=%b last=%b addr=%0d required dout=%h valid=1 last=%b addr=%0d",
                   cyc, dout, dout_valid, dout_last, rd_addr, prev_dout, prev_last, prev_addr);
        end
      end
      if (done) begin
        total++;
        if (idx != nwords || cyc != last_xfer + 1) begin
          bad++;
          $display("FAIL done_timing cyc=%0d words=%0d required cyc=%0d words=%0d", cyc, idx, last_xfer + 1, nwords);
        end
        finished = 1;
        break;
      end
      total++;
      if (busy !== 1'b1 || (dout_last && !dout_valid)) begin
        bad++;
        $display("FAIL busy_last cyc=%0d busy=%b last=%b valid=%b required busy=1 last only with valid", cyc, busy, dout_last, dout_valid);
      end
      if (idx == stall_idx && dout_valid && stall_left > 0) begin
        dout_ready = 1'b0;
        stall_left--;
      end else begin
        dout_ready = ($urandom_range(99) < ready_pct);
      end
      if (cyc == restart_cyc) begin
        start = 1'b1; len = NBADD'($urandom);
      end else begin
        start = 1'b0;
      end
      if (dout_valid && dout_ready) begin
        total++;
        if (idx >= nwords) begin
          bad++;
          $display("FAIL extra_word cyc=%0d dout=%h required no more than %0d words", cyc, dout, nwords);
        end else if (dout !== exp_q[idx] || dout_last !== (idx == nwords - 1) ||
                     (idx < ndata && rd_addr !== NBADD'(idx % DEPTH)) ||
                     (cadence && cyc != 1 + 2 * idx)) begin
          bad++;
          $display("FAIL word%0d dout=%h last=%b addr=%0d cyc=%0d required dout=%h last=%b addr=%0d cyc=%0d",
                   idx, dout, dout_last, rd_addr, cyc, exp_q[idx], (idx == nwords - 1), idx % DEPTH, 1 + 2 * idx);
        end
        last_word = dout;
        last_xfer = cyc;
        idx++;
        words_seen = idx;
      end
      prev_hold = dout_valid && !dout_ready;
      prev_dout = dout; prev_last = dout_last; prev_addr = rd_addr;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; dout_ready = 1'b0;
    if (!finished) begin
      total++; bad++;
      $display("FAIL timeout words=%0d required %0d words and a done pulse", idx, nwords);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_done busy=%b done=%b valid=%b required 0 0 0", busy, done, dout_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dout_ready = 1'b0; len = '0;
    fill_random();
    #1;
    total++;
    if ({rd_addr, dout, dout_valid, dout_last, busy, done} !== '0) begin
      bad++; $display("FAIL reset_state addr=%0d dout=%h valid=%b busy=%b required all zero", rd_addr, dout, dout_valid, busy);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    total++;
    if ({rd_addr, dout, dout_valid, dout_last, busy, done} !== '0) begin
      bad++; $display("FAIL reset_held addr=%0d dout=%h valid=%b busy=%b required all zero", rd_addr, dout, dout_valid, busy);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[0] = 32'h0001_0002; mem[1] = 32'h0003_0004; mem[2] = 32'h0005_0006;
    readout(3, 100, -1, 0, -1, 1'b1);
  endtask

  task automatic test_stall();
    mem[0] = 32'h0001_0002; mem[1] = 32'h0003_0004; mem[2] = 32'h0005_0006;
    readout(3, 100, 1, 5, -1, 1'b0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < DEPTH; i++) mem[i] = W'(i);
    readout(0, 100, -1, 0, -1, 1'b1);
    total++;
    if (rd_addr !== '0 || words_seen != DEPTH + (last_word == W'(120) && words_seen > DEPTH ? 1 : 0) && words_seen != DEPTH) begin
      bad++; $display("FAIL wrap addr=%0d words=%0d required addr=0 words>=%0d", rd_addr, words_seen, DEPTH);
    end
  endtask

  task automatic test_restart_ignored();
    fill_random();
    readout(6, 100, -1, 0, 3, 1'b1);
  endtask

  task automatic test_reset_abort();
    fill_random();
    @(negedge clk);
    len = NBADD'(8); start = 1'b1; dout_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    dout_ready = 1'b0;
    total++;
    if (dout_valid !== 1'b1 || dout !== mem[1]) begin
      bad++; $display("FAIL abort_word2 valid=%b dout=%h required valid=1 dout=%h", dout_valid, dout, mem[1]);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({rd_addr, dout, dout_valid, dout_last, busy, done} !== '0) begin
      bad++; $display("FAIL abort_zero addr=%0d dout=%h valid=%b busy=%b done=%b required all zero", rd_addr, dout, dout_valid, busy, done);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL abort_nodone done=%b busy=%b required 0 0", done, busy);
      end
    end
    rst = 1'b0;
    readout(5, 100, -1, 0, -1, 1'b1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      fill_random();
      readout($urandom_range(15), $urandom_range(100, 30), -1, 0, -1, 1'b0);
    end
  endtask

  task automatic test_cksum();
`ifdef BUFF_READER_CKSUM_EN
    mem[0] = 32'hFFFF_FFFF; mem[1] = 32'h0000_0002;
    readout(2, 100, -1, 0, -1, 1'b1);
    total++;
    if (last_word !== 32'h0000_0001 || words_seen != 3) begin
      bad++; $display("FAIL cksum_word word=%h count=%0d required 00000001 count=3", last_word, words_seen);
    end
`else
    mem[0] = 32'hFFFF_FFFF; mem[1] = 32'h0000_0002;
    readout(2, 100, -1, 0, -1, 1'b1);
    total++;
    if (last_word !== 32'h0000_0002 || words_seen != 2) begin
      bad++; $display("FAIL final_word word=%h count=%0d required 00000002 count=2", last_word, words_seen);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_restart_ignored();
    test_reset_abort();
    test_random();
    test_cksum();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
